register_file: RTL and testbench

//   Parametrised successor of the DiBU main register bank: DEPTH x WIDTH storage, two read ports, one write port.

---
 rtl/register_file_pkg.sv | 36 +++
 rtl/register_file_if.sv | 35 +++
 rtl/register_file_scoreboard.sv | 40 ++++
 rtl/register_file.sv | 142 ++++++++++++++
 tb/tb_register_file.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_pkg.sv
// Shared definitions for the register_file slice: bank defaults, the index-width
// helper and the encoding of where a read port takes its data from.
package register_file_pkg;

    localparam int DIBU_WORD_W = 8;
    localparam int DIBU_NREGS  = 8;

    typedef enum logic [1:0] {
        RD_ZERO   = 2'd0,
        RD_BYPASS = 2'd1,
        RD_BANK   = 2'd2
    } rd_src_e;

    // Never returns less than 1 so a two-entry bank still gets a real index bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    function automatic rd_src_e pick_source(input logic addressable, input logic bypass_hit);
        rd_src_e src;
        if (!addressable) begin
            src = RD_ZERO;
        end else if (bypass_hit) begin
            src = RD_BYPASS;
        end else begin
            src = RD_BANK;
        end
        return src;
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Decode/writeback side of the register bank: read and reserve requests from decode,
// writes from writeback, and the registered read data plus scoreboard going back.
interface register_file_if
    import register_file_pkg::*;
#(
    parameter int WIDTH = DIBU_WORD_W,
    parameter int DEPTH = DIBU_NREGS
);
    localparam int IW = clog2(DEPTH);

    logic             rd_en;
    logic [IW-1:0]    ri_a;
    logic [IW-1:0]    ri_b;
    logic             wr_en;
    logic [IW-1:0]    ri_d;
    logic [WIDTH-1:0] d;
    logic             rsv_en;
    logic [IW-1:0]    ri_rsv;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy_a;
    logic             busy_b;
    logic [DEPTH-1:0] busy_mask;

    modport master (
        output rd_en, ri_a, ri_b, wr_en, ri_d, d, rsv_en, ri_rsv,
        input  a, b, busy_a, busy_b, busy_mask
    );

    modport slave (
        input  rd_en, ri_a, ri_b, wr_en, ri_d, d, rsv_en, ri_rsv,
        output a, b, busy_a, busy_b, busy_mask
    );

endinterface

// File: rtl/register_file_scoreboard.sv
// Busy-bit scoreboard: one flop per register, set by a reservation, cleared by
// the matching writeback; a reservation on the same edge as a clear wins.
module rf_scoreboard
    import register_file_pkg::*;
#(
    parameter int DEPTH   = DIBU_NREGS,
    parameter int IW      = clog2(DEPTH),
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_en,
    input  logic [IW-1:0]    clr_idx,
    input  logic             set_en,
    input  logic [IW-1:0]    set_idx,
    output logic [DEPTH-1:0] busy_mask
);

    logic [DEPTH-1:0] busy_q;

    // Reserve is checked before clear: a new producer outranks the retiring one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((ZERO_R0 != 0) && (i == 0)) begin
                    busy_q[i] <= 1'b0;
                end else if (set_en && (set_idx == IW'(i))) begin
                    busy_q[i] <= 1'b1;
                end else if (clr_en && (clr_idx == IW'(i))) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    assign busy_mask = busy_q;

endmodule

// File: rtl/register_file.sv
// DEPTH x WIDTH register bank with two registered read ports, one write port,
// optional write-to-read bypass, optional hard-wired r0 and a busy scoreboard.
module register_file
    import register_file_pkg::*;
#(
    parameter int WIDTH   = DIBU_WORD_W,
    parameter int DEPTH   = DIBU_NREGS,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic            clk,
    input  logic            rst,
    register_file_if.slave  bus
);

    localparam int IW    = clog2(DEPTH);
    localparam int NSLOT = 1 << IW;

    logic [NSLOT-1:0] in_range;
    logic [WIDTH-1:0] bank [DEPTH];
    logic [DEPTH-1:0] busy_mask;
    logic             ok_a;
    logic             ok_b;
    logic             ok_d;
    logic             ok_rsv;
    logic             wr_ok;
    logic             rsv_ok;
    rd_src_e          src_a;
    rd_src_e          src_b;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;
    logic             next_busy_a;
    logic             next_busy_b;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             busy_a_q;
    logic             busy_b_q;

    // Index slots past DEPTH exist only when DEPTH is not a power of two.
    for (genvar i = 0; i < NSLOT; i++) begin : g_range
        assign in_range[i] = (i < DEPTH);
    end

    function automatic logic is_r0(input logic [IW-1:0] idx);
        return (ZERO_R0 != 0) && (idx == '0);
    endfunction

    assign ok_a   = in_range[bus.ri_a]   && !is_r0(bus.ri_a);
    assign ok_b   = in_range[bus.ri_b]   && !is_r0(bus.ri_b);
    assign ok_d   = in_range[bus.ri_d]   && !is_r0(bus.ri_d);
    assign ok_rsv = in_range[bus.ri_rsv] && !is_r0(bus.ri_rsv);

    assign wr_ok  = bus.wr_en  && ok_d;
    assign rsv_ok = bus.rsv_en && ok_rsv;

    assign src_a = pick_source(ok_a, (BYPASS != 0) && wr_ok && (bus.ri_d == bus.ri_a));
    assign src_b = pick_source(ok_b, (BYPASS != 0) && wr_ok && (bus.ri_d == bus.ri_b));

    // A bypassed read still reports busy when a same-edge reservation claims the register.
    always_comb begin
        next_a      = '0;
        next_busy_a = 1'b0;
        case (src_a)
            RD_BYPASS: begin
                next_a      = bus.d;
                next_busy_a = rsv_ok && (bus.ri_rsv == bus.ri_a);
            end
            RD_BANK: begin
                next_a      = bank[bus.ri_a];
                next_busy_a = busy_mask[bus.ri_a];
            end
            default: begin
                next_a      = '0;
                next_busy_a = 1'b0;
            end
        endcase
    end

    always_comb begin
        next_b      = '0;
        next_busy_b = 1'b0;
        case (src_b)
            RD_BYPASS: begin
                next_b      = bus.d;
                next_busy_b = rsv_ok && (bus.ri_rsv == bus.ri_b);
            end
            RD_BANK: begin
                next_b      = bank[bus.ri_b];
                next_busy_b = busy_mask[bus.ri_b];
            end
            default: begin
                next_b      = '0;
                next_busy_b = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (wr_ok) begin
            bank[bus.ri_d] <= bus.d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            busy_a_q <= 1'b0;
            busy_b_q <= 1'b0;
        end else if (bus.rd_en) begin
            a_q      <= next_a;
            b_q      <= next_b;
            busy_a_q <= next_busy_a;
            busy_b_q <= next_busy_b;
        end
    end

    rf_scoreboard #(
        .DEPTH   (DEPTH),
        .IW      (IW),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .clr_en    (wr_ok),
        .clr_idx   (bus.ri_d),
        .set_en    (rsv_ok),
        .set_idx   (bus.ri_rsv),
        .busy_mask (busy_mask)
    );

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy_a    = busy_a_q;
    assign bus.busy_b    = busy_b_q;
    assign bus.busy_mask = busy_mask;

endmodule

// File: tb/tb_register_file.sv
// Drives two register_file configurations from one stimulus stream: dut0 is
// DEPTH=8/BYPASS=1/ZERO_R0=0, dut1 is DEPTH=6/BYPASS=0/ZERO_R0=1.
module tb_register_file;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd_en;
    logic [2:0] ri_a;
    logic [2:0] ri_b;
    logic       wr_en;
    logic [2:0] ri_d;
    logic [7:0] d;
    logic       rsv_en;
    logic [2:0] ri_rsv;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] m_bank [2][8];
    logic       m_busy [2][8];
    logic [7:0] m_a  [2];
    logic [7:0] m_b  [2];
    logic       m_ba [2];
    logic       m_bb [2];

    always #5 clk = ~clk;

    register_file_if #(.WIDTH(8), .DEPTH(8)) if0 ();
    register_file_if #(.WIDTH(8), .DEPTH(6)) if1 ();

    assign if0.rd_en  = rd_en;
    assign if0.ri_a   = ri_a;
    assign if0.ri_b   = ri_b;
    assign if0.wr_en  = wr_en;
    assign if0.ri_d   = ri_d;
    assign if0.d      = d;
    assign if0.rsv_en = rsv_en;
    assign if0.ri_rsv = ri_rsv;
    assign if1.rd_en  = rd_en;
    assign if1.ri_a   = ri_a;
    assign if1.ri_b   = ri_b;
    assign if1.wr_en  = wr_en;
    assign if1.ri_d   = ri_d;
    assign if1.d      = d;
    assign if1.rsv_en = rsv_en;
    assign if1.ri_rsv = ri_rsv;

    register_file #(.WIDTH(8), .DEPTH(8), .BYPASS(1), .ZERO_R0(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    register_file #(.WIDTH(8), .DEPTH(6), .BYPASS(0), .ZERO_R0(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    function automatic int cfg_depth(input int k);
        return (k == 0) ? 8 : 6;
    endfunction

    function automatic bit cfg_bypass(input int k);
        return (k == 0);
    endfunction

    function automatic bit cfg_zero(input int k);
        return (k == 1);
    endfunction

    // A register that exists and is not the hard-wired zero.
    function automatic bit usable(input int k, input int idx);
        return (idx < cfg_depth(k)) && !(cfg_zero(k) && idx == 0);
    endfunction

    function automatic void model_read(input int k, input int idx,
                                       output logic [7:0] val, output logic bsy);
        val = 8'h00;
        bsy = 1'b0;
        if (usable(k, idx)) begin
            if (cfg_bypass(k) && wr_en && int'(ri_d) == idx) begin
                val = d;
                bsy = rsv_en && (int'(ri_rsv) == idx);
            end else begin
                val = m_bank[k][idx];
                bsy = m_busy[k][idx];
            end
        end
    endfunction

    function automatic logic [7:0] model_mask(input int k);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < cfg_depth(k); i++) begin
            m[i] = m_busy[k][i];
        end
        return m;
    endfunction

    // Reads see the pre-edge state; the write lands, then a reservation overrides busy.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 8; i++) begin
                    m_bank[k][i] = 8'h00;
                    m_busy[k][i] = 1'b0;
                end
                m_a[k]  = 8'h00;
                m_b[k]  = 8'h00;
                m_ba[k] = 1'b0;
                m_bb[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (rd_en) begin
                    model_read(k, int'(ri_a), m_a[k], m_ba[k]);
                    model_read(k, int'(ri_b), m_b[k], m_bb[k]);
                end
                if (wr_en && usable(k, int'(ri_d))) begin
                    m_bank[k][ri_d] = d;
                    m_busy[k][ri_d] = 1'b0;
                end
                if (rsv_en && usable(k, int'(ri_rsv))) begin
                    m_busy[k][ri_rsv] = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareDut(input int k, input logic [7:0] a, input logic [7:0] b,
                              input logic ba, input logic bb, input logic [7:0] mask);
        checkOutput($sformatf("dut%0d.a", k),         32'(a),    32'(m_a[k]));
        checkOutput($sformatf("dut%0d.b", k),         32'(b),    32'(m_b[k]));
        checkOutput($sformatf("dut%0d.busy_a", k),    32'(ba),   32'(m_ba[k]));
        checkOutput($sformatf("dut%0d.busy_b", k),    32'(bb),   32'(m_bb[k]));
        checkOutput($sformatf("dut%0d.busy_mask", k), 32'(mask), 32'(model_mask(k)));
    endtask

    always @(negedge clk) begin
        compareDut(0, if0.a, if0.b, if0.busy_a, if0.busy_b, if0.busy_mask);
        compareDut(1, if1.a, if1.b, if1.busy_a, if1.busy_b, {2'b00, if1.busy_mask});
    end

    // Inputs change just after the falling edge and are held across one rising edge.
    task automatic applyStimulus(input logic r, input logic [2:0] ia, input logic [2:0] ib,
                                 input logic w, input logic [2:0] id, input logic [7:0] dd,
                                 input logic s, input logic [2:0] ir);
        @(negedge clk);
        #1;
        rd_en  = r;
        ri_a   = ia;
        ri_b   = ib;
        wr_en  = w;
        ri_d   = id;
        d      = dd;
        rsv_en = s;
        ri_rsv = ir;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rd_en  = 1'b0;
        ri_a   = 3'd0;
        ri_b   = 3'd0;
        wr_en  = 1'b0;
        ri_d   = 3'd0;
        d      = 8'h00;
        rsv_en = 1'b0;
        ri_rsv = 3'd0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(1, 3'd3, 3'd5, 0, 3'd0, 8'h00, 0, 3'd0);
        checkOutput("t1_a0",    32'(if0.a),         32'h0);
        checkOutput("t1_b0",    32'(if0.b),         32'h0);
        checkOutput("t1_mask0", 32'(if0.busy_mask), 32'h0);
        checkOutput("t1_mask1", 32'(if1.busy_mask), 32'h0);

        applyStimulus(0, 3'd0, 3'd0, 1, 3'd2, 8'hA5, 0, 3'd0);
        applyStimulus(1, 3'd2, 3'd2, 0, 3'd0, 8'h00, 0, 3'd0);
        checkOutput("t2_a0", 32'(if0.a), 32'hA5);
        checkOutput("t2_a1", 32'(if1.a), 32'hA5);

        applyStimulus(0, 3'd0, 3'd0, 1, 3'd4, 8'h77, 0, 3'd0);
        applyStimulus(1, 3'd4, 3'd4, 1, 3'd4, 8'h3C, 0, 3'd0);
        checkOutput("t3_bypass_a0", 32'(if0.a),      32'h3C);
        checkOutput("t3_bypass_b0", 32'(if0.b),      32'h3C);
        checkOutput("t3_bypass_busy0", 32'(if0.busy_a), 32'h0);
        checkOutput("t3_nobypass_a1", 32'(if1.a),    32'h77);
        checkOutput("t3_nobypass_b1", 32'(if1.b),    32'h77);
        applyStimulus(1, 3'd4, 3'd4, 0, 3'd0, 8'h00, 0, 3'd0);
        checkOutput("t3_after_a1", 32'(if1.a), 32'h3C);

        applyStimulus(0, 3'd0, 3'd0, 0, 3'd0, 8'h00, 1, 3'd6);
        checkOutput("t4_mask0",     32'(if0.busy_mask), 32'h40);
        checkOutput("t4_mask1_oor", 32'(if1.busy_mask), 32'h00);
        applyStimulus(1, 3'd6, 3'd6, 0, 3'd0, 8'h00, 0, 3'd0);
        checkOutput("t4_busy_a0", 32'(if0.busy_a), 32'h1);
        checkOutput("t4_busy_a1", 32'(if1.busy_a), 32'h0);
        applyStimulus(0, 3'd0, 3'd0, 1, 3'd6, 8'h11, 0, 3'd0);
        checkOutput("t4_clear_mask0", 32'(if0.busy_mask), 32'h00);
        applyStimulus(0, 3'd0, 3'd0, 1, 3'd6, 8'h22, 1, 3'd6);
        checkOutput("t4_rsv_wins_mask0", 32'(if0.busy_mask), 32'h40);
        applyStimulus(1, 3'd6, 3'd0, 0, 3'd0, 8'h00, 0, 3'd0);
        checkOutput("t4_rsv_wins_a0",  32'(if0.a),      32'h22);
        checkOutput("t4_rsv_wins_ba0", 32'(if0.busy_a), 32'h1);
        applyStimulus(1, 3'd6, 3'd6, 1, 3'd6, 8'h33, 1, 3'd6);
        checkOutput("t4_bypass_rsv_a0",  32'(if0.a),      32'h33);
        checkOutput("t4_bypass_rsv_ba0", 32'(if0.busy_a), 32'h1);

        applyStimulus(0, 3'd0, 3'd0, 1, 3'd0, 8'hFF, 1, 3'd0);
        applyStimulus(1, 3'd0, 3'd0, 0, 3'd0, 8'h00, 0, 3'd0);
        checkOutput("t5_r0_a1",    32'(if1.a),         32'h0);
        checkOutput("t5_r0_ba1",   32'(if1.busy_a),    32'h0);
        checkOutput("t5_r0_mask1", 32'(if1.busy_mask), 32'h0);
        checkOutput("t5_r0_a0",    32'(if0.a),         32'hFF);
        checkOutput("t5_r0_mask0", 32'(if0.busy_mask), 32'h41);
        applyStimulus(0, 3'd0, 3'd0, 1, 3'd5, 8'h66, 0, 3'd0);
        applyStimulus(0, 3'd0, 3'd0, 1, 3'd7, 8'h5A, 0, 3'd0);
        applyStimulus(1, 3'd7, 3'd5, 0, 3'd0, 8'h00, 0, 3'd0);
        checkOutput("t5_oor_a1", 32'(if1.a), 32'h00);
        checkOutput("t5_r5_b1",  32'(if1.b), 32'h66);
        checkOutput("t5_r7_a0",  32'(if0.a), 32'h5A);
        applyStimulus(1, 3'd0, 3'd0, 1, 3'd0, 8'hEE, 0, 3'd0);
        checkOutput("t5_r0_bypass_a1", 32'(if1.a), 32'h00);
        checkOutput("t5_r0_bypass_a0", 32'(if0.a), 32'hEE);
        applyStimulus(0, 3'd1, 3'd1, 1, 3'd1, 8'h99, 0, 3'd0);
        checkOutput("t5_hold_a0", 32'(if0.a), 32'hEE);

        @(negedge clk);
        #1;
        rd_en  = 1'b1;
        ri_a   = 3'd2;
        ri_b   = 3'd2;
        wr_en  = 1'b1;
        ri_d   = 3'd3;
        d      = 8'hC3;
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_async_a0",    32'(if0.a),         32'h0);
        checkOutput("t6_async_mask0", 32'(if0.busy_mask), 32'h0);
        checkOutput("t6_async_b1",    32'(if1.b),         32'h0);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        #2 rst = 1'b0;
        applyStimulus(1, 3'd3, 3'd2, 0, 3'd0, 8'h00, 0, 3'd0);
        checkOutput("t6_lost_a0", 32'(if0.a), 32'h0);
        checkOutput("t6_lost_b0", 32'(if0.b), 32'h0);

        for (int n = 0; n < 60; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        applyStimulus(0, 3'd0, 3'd0, 0, 3'd0, 8'h00, 0, 3'd0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
